// File: rtl/debug_pkg.sv
// Shared debug-unit definitions: host command codes, step FSM state encoding,
// default step-counter width.
package debug_pkg;

    localparam logic [7:0] HOST_CMD_LOAD = 8'h01;
    localparam logic [7:0] HOST_CMD_FAST = 8'h02;
    localparam logic [7:0] HOST_CMD_STEP = 8'h03;
    localparam logic [7:0] HOST_CMD_NEXT = 8'h04;
    localparam logic [7:0] HOST_CMD_EXIT = 8'h05;

    localparam int unsigned DBG_CNT_W = 32;

    localparam int unsigned ST_W = 3;
    localparam logic [ST_W-1:0] ENC_IDLE      = 3'd0;
    localparam logic [ST_W-1:0] ENC_WAIT_CMD  = 3'd1;
    localparam logic [ST_W-1:0] ENC_STEP      = 3'd2;
    localparam logic [ST_W-1:0] ENC_SEND      = 3'd3;
    localparam logic [ST_W-1:0] ENC_WAIT_SEND = 3'd4;
    localparam logic [ST_W-1:0] ENC_DONE      = 3'd5;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE      = ENC_IDLE,
        ST_WAIT_CMD  = ENC_WAIT_CMD,
        ST_STEP      = ENC_STEP,
        ST_SEND      = ENC_SEND,
        ST_WAIT_SEND = ENC_WAIT_SEND,
        ST_DONE      = ENC_DONE
    } step_state_e;

endpackage

// File: rtl/sat_counter.sv
// Width-parameterised up-counter with synchronous clear that holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/debug_step_ctrl.sv
// Step-mode scheduler: one pipeline step per host CMD_NEXT, each followed by a
// pipe-state dump. Step counter and o_clk_count exist only with STEP_CYCLE_COUNT_EN.
module debug_step_ctrl
    import debug_pkg::*;
#(
    parameter logic [7:0] CMD_NEXT = HOST_CMD_NEXT,
    parameter logic [7:0] CMD_EXIT = HOST_CMD_EXIT
`ifdef STEP_CYCLE_COUNT_EN
    ,
    parameter int unsigned CNT_W = DBG_CNT_W
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             is_start,
    input  logic [7:0]       i_rx_data,
    input  logic             is_rx_done,
    input  logic             is_stop_pipe,
    input  logic             is_send_done,
    output logic             os_step,
    output logic             os_start_send,
    output logic             os_done,
    output logic             o_busy
`ifdef STEP_CYCLE_COUNT_EN
    ,
    output logic [CNT_W-1:0] o_clk_count
`endif
);

    step_state_e state, state_nxt;
    logic        stop_latch, stop_nxt;

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            stop_latch    <= 1'b0;
            os_step       <= 1'b0;
            os_start_send <= 1'b0;
            os_done       <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            state         <= state_nxt;
            stop_latch    <= stop_nxt;
            os_step       <= (state_nxt == ST_STEP);
            os_start_send <= (state_nxt == ST_SEND);
            os_done       <= (state_nxt == ST_DONE);
            o_busy        <= (state_nxt != ST_IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        stop_nxt  = stop_latch;
        unique case (state)
            ST_IDLE: begin
                stop_nxt = 1'b0;
                if (is_start) state_nxt = ST_WAIT_CMD;
            end
            ST_WAIT_CMD: begin
                if (is_rx_done && (i_rx_data == CMD_NEXT)) begin
                    state_nxt = ST_STEP;
                end else if (is_rx_done && (i_rx_data == CMD_EXIT)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_STEP: begin
                if (is_stop_pipe) stop_nxt = 1'b1;
                state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (is_stop_pipe) stop_nxt = 1'b1;
                state_nxt = ST_WAIT_SEND;
            end
            ST_WAIT_SEND: begin
                // A halt seen in the same cycle as send_done still ends the session.
                if (is_stop_pipe) stop_nxt = 1'b1;
                if (is_send_done) begin
                    state_nxt = (stop_latch || is_stop_pipe) ? ST_DONE : ST_WAIT_CMD;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

`ifdef STEP_CYCLE_COUNT_EN
    sat_counter #(
        .W(CNT_W)
    ) u_step_cnt (
        .clk(clk),
        .clr(rst || (state == ST_IDLE)),
        .en (state == ST_STEP),
        .q  (o_clk_count)
    );
`endif

endmodule

// File: tb/tb_debug_step_ctrl.sv
// Bench for debug_step_ctrl: vector table, hand sequences, random run vs timeline model.
module tb_debug_step_ctrl;
    import debug_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       is_start = 1'b0;
    logic [7:0] i_rx_data = 8'h00;
    logic       is_rx_done = 1'b0;
    logic       is_stop_pipe = 1'b0;
    logic       is_send_done = 1'b0;
    logic       os_step, os_start_send, os_done, o_busy;
`ifdef STEP_CYCLE_COUNT_EN
    logic [DBG_CNT_W-1:0] o_clk_count;
`endif

    always #5 clk = ~clk;

    debug_step_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .is_start     (is_start),
        .i_rx_data    (i_rx_data),
        .is_rx_done   (is_rx_done),
        .is_stop_pipe (is_stop_pipe),
        .is_send_done (is_send_done),
        .os_step      (os_step),
        .os_start_send(os_start_send),
        .os_done      (os_done),
        .o_busy       (o_busy)
`ifdef STEP_CYCLE_COUNT_EN
        ,
        .o_clk_count  (o_clk_count)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_step_pulses = 0;

    // Timeline model: remembers the edge at which a command was accepted and
    // derives every output from the age of that command.
    int          edge_no = 0;
    bit          m_active = 0;
    int          m_cmd_edge = -1;
    int          m_done_edge = -1;
    bit          m_halt = 0;
    longint      m_steps = 0;
    logic [3:0]  m_exp = '0;   // {step, start_send, done, busy}

    function automatic void model_edge();
        int age;
        edge_no = edge_no + 1;
        m_exp = '0;
        if (rst) begin
            m_active = 0; m_cmd_edge = -1; m_done_edge = -1; m_halt = 0; m_steps = 0;
        end else if (!m_active) begin
            m_steps = 0;
            m_halt  = 0;
            if (is_start) begin
                m_active = 1;
                m_cmd_edge = -1;
            end
        end else if (m_done_edge >= 0) begin
            m_active = 0;
            m_done_edge = -1;
        end else if (m_cmd_edge < 0) begin
            if (is_rx_done && i_rx_data == HOST_CMD_NEXT) begin
                m_cmd_edge = edge_no;
                m_exp[3] = 1'b1;
            end else if (is_rx_done && i_rx_data == HOST_CMD_EXIT) begin
                m_done_edge = edge_no;
                m_exp[1] = 1'b1;
            end
        end else begin
            age = edge_no - m_cmd_edge;
            if (is_stop_pipe) m_halt = 1;
            if (age == 1) begin
                m_exp[2] = 1'b1;
                if (m_steps < ((longint'(1) << DBG_CNT_W) - 1)) m_steps = m_steps + 1;
            end else if (age >= 3 && is_send_done) begin
                m_cmd_edge = -1;
                if (m_halt) begin
                    m_done_edge = edge_no;
                    m_exp[1] = 1'b1;
                end
            end
        end
        m_exp[0] = m_active;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", name, edge_no, act, exp);
        end
    endtask

    function automatic logic [3:0] dut_out();
        return {os_step, os_start_send, os_done, o_busy};
    endfunction

    task automatic drive(input bit r, input bit s, input bit rd, input logic [7:0] d,
                         input bit sp, input bit sd);
        rst = r; is_start = s; is_rx_done = rd; i_rx_data = d;
        is_stop_pipe = sp; is_send_done = sd;
        @(posedge clk);
        model_edge();
        #1;
        n_step_pulses += int'(os_step);
    endtask

    task automatic check_model(input string name);
        check(name, longint'(dut_out()), longint'(m_exp));
`ifdef STEP_CYCLE_COUNT_EN
        check({name, "_cnt"}, longint'(o_clk_count), m_steps);
`endif
    endtask

    typedef struct {
        bit         r, s, rd;
        logic [7:0] d;
        bit         sp, sd;
        logic [3:0] exp;
        longint     cnt;
    } vec_t;

    vec_t tbl[31];

    function automatic vec_t mk(bit r, bit s, bit rd, logic [7:0] d, bit sp, bit sd,
                                logic [3:0] exp, longint cnt);
        vec_t v;
        v.r = r; v.s = s; v.rd = rd; v.d = d; v.sp = sp; v.sd = sd;
        v.exp = exp; v.cnt = cnt;
        return v;
    endfunction

    initial begin
        bit got;
        int steps_before;
        // exp = {step, start_send, done, busy}
        tbl[0]  = mk(1,0,0,8'h00,0,0, 4'b0000, 0);
        tbl[1]  = mk(0,0,0,8'h00,0,0, 4'b0000, 0);
        tbl[2]  = mk(0,1,0,8'h00,0,0, 4'b0001, 0);
        tbl[3]  = mk(0,0,1,8'h04,0,0, 4'b1001, 0);
        tbl[4]  = mk(0,0,0,8'h00,0,0, 4'b0101, 1);
        tbl[5]  = mk(0,0,0,8'h00,0,0, 4'b0001, 1);
        tbl[6]  = mk(0,0,1,8'h04,0,0, 4'b0001, 1);   // NEXT in WAIT_SEND dropped
        tbl[7]  = mk(0,0,0,8'h00,0,1, 4'b0001, 1);
        tbl[8]  = mk(0,0,1,8'h7F,0,0, 4'b0001, 1);   // unknown byte ignored
        tbl[9]  = mk(0,0,0,8'h00,0,0, 4'b0001, 1);
        tbl[10] = mk(0,0,1,8'h04,0,0, 4'b1001, 1);
        tbl[11] = mk(0,0,0,8'h00,1,0, 4'b0101, 2);   // halt during STEP
        tbl[12] = mk(0,0,0,8'h00,0,0, 4'b0001, 2);
        tbl[13] = mk(0,0,0,8'h00,0,1, 4'b0011, 2);
        tbl[14] = mk(0,0,1,8'h04,0,0, 4'b0000, 2);
        tbl[15] = mk(0,0,1,8'h04,0,0, 4'b0000, 0);
        tbl[16] = mk(0,1,0,8'h00,0,0, 4'b0001, 0);
        tbl[17] = mk(0,0,1,8'h05,0,0, 4'b0011, 0);   // EXIT
        tbl[18] = mk(0,0,0,8'h00,0,0, 4'b0000, 0);
        tbl[19] = mk(0,1,0,8'h00,0,0, 4'b0001, 0);
        tbl[20] = mk(0,0,1,8'h04,0,0, 4'b1001, 0);
        tbl[21] = mk(0,0,0,8'h00,0,0, 4'b0101, 1);
        tbl[22] = mk(0,0,0,8'h00,0,0, 4'b0001, 1);
        tbl[23] = mk(1,0,0,8'h00,0,0, 4'b0000, 0);   // reset in WAIT_SEND
        tbl[24] = mk(0,0,0,8'h00,0,0, 4'b0000, 0);
        tbl[25] = mk(0,1,0,8'h00,0,0, 4'b0001, 0);
        tbl[26] = mk(0,0,1,8'h04,0,0, 4'b1001, 0);
        tbl[27] = mk(0,0,0,8'h00,0,0, 4'b0101, 1);
        tbl[28] = mk(0,0,0,8'h00,0,0, 4'b0001, 1);
        tbl[29] = mk(0,0,0,8'h00,1,1, 4'b0011, 1);   // halt and send_done together
        tbl[30] = mk(0,0,0,8'h00,0,0, 4'b0000, 1);

        for (int i = 0; i < 31; i++) begin
            drive(tbl[i].r, tbl[i].s, tbl[i].rd, tbl[i].d, tbl[i].sp, tbl[i].sd);
            check($sformatf("vec%0d", i), longint'(dut_out()), longint'(tbl[i].exp));
`ifdef STEP_CYCLE_COUNT_EN
            check($sformatf("vec%0d_cnt", i), longint'(o_clk_count), tbl[i].cnt);
`endif
        end

        // Three steps, each dump completing five cycles after start_send.
        drive(1,0,0,8'h00,0,0);
        drive(0,1,0,8'h00,0,0);
        check_model("three_start");
        steps_before = n_step_pulses;
        for (int k = 0; k < 3; k++) begin
            drive(0,0,1,HOST_CMD_NEXT,0,0);
            check_model("three_next");
            got = 1'b0;
            for (int w = 0; w < 8 && !got; w++) begin
                drive(0,0,0,8'h00,0,0);
                check_model("three_wait");
                got = os_start_send;
            end
            check("three_send_seen", longint'(got), 1);
            for (int w = 0; w < 4; w++) begin
                drive(0,0,0,8'h00,0,0);
                check_model("three_dump");
            end
            drive(0,0,0,8'h00,0,1);
            check("three_back_wait_cmd", longint'({os_done, o_busy}), 1);
        end
        check("three_step_pulses", longint'(n_step_pulses - steps_before), 3);
`ifdef STEP_CYCLE_COUNT_EN
        check("three_count", longint'(o_clk_count), 3);
`endif

        // Random traffic against the model.
        drive(1,0,0,8'h00,0,0);
        check_model("rand_reset");
        for (int c = 0; c < 4000; c++) begin
            bit r, s, rd, sp, sd;
            logic [7:0] d;
            int pick;
            r  = ($urandom_range(0, 299) == 0);
            s  = ($urandom_range(0, 5) == 0);
            rd = ($urandom_range(0, 2) == 0);
            sp = ($urandom_range(0, 24) == 0);
            sd = ($urandom_range(0, 3) == 0);
            pick = int'($urandom_range(0, 9));
            if (pick < 6)       d = HOST_CMD_NEXT;
            else if (pick == 6) d = HOST_CMD_EXIT;
            else                d = 8'($urandom_range(0, 255));
            drive(r, s, rd, d, sp, sd);
            check_model("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
